// File: rtl/matrix_inverse_seq.sv
// matrix_inverse_seq
//   Sequential fraction-free Gauss-Jordan inversion of an N x N signed
//   matrix. The matrix is streamed in row-major, reduced in place together
//   with an augmented identity, then streamed out as numerators aug[r][c]
//   with a per-row denominator A[r][r]. Everything wraps modulo 2^W.
// Ports
//   clk, reset                    clock, async active-high reset
//   load_valid/load_ready/load_data   input element stream (row-major)
//   out_valid/out_ready           output handshake
//   out_data, out_denom, out_last numerator, row denominator, final beat
//   done, singular                one-cycle job-end pulse, singular flag
module matrix_inverse_seq #(
   parameter int N = 5,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [W-1:0] load_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [W-1:0] out_denom,
   output logic         out_last,
   output logic         done,
   output logic         singular
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [2:0] {IDLE, SEARCH, SWAP, ELIM, OUTPUT} state_t;
   state_t state, state_n;

   // r/c index the element being loaded in IDLE and the beat being sent
   // in OUTPUT; both phases walk the matrix row-major from (0,0).
   logic [IW-1:0] k, p, i, r, c;
   logic          armed, done_q, sing_q;
   logic          load_fire, out_fire, piv_nz, rc_last;

   logic signed [W-1:0] a   [N][N];
   logic signed [W-1:0] aug [N][N];
   logic signed [W-1:0] row_a [N];
   logic signed [W-1:0] row_g [N];

   // armed keeps load_ready low until the first edge after reset; the
   // done_q term makes the cycle after the done pulse the first load slot.
   assign load_ready = (state == IDLE) && armed && !done_q;
   assign load_fire  = load_valid && load_ready;
   assign out_valid  = (state == OUTPUT);
   assign out_fire   = out_valid && out_ready;
   assign rc_last    = (r == LAST) && (c == LAST);
   assign out_last   = out_valid && rc_last;
   assign out_data   = out_valid ? aug[r][c] : '0;
   assign out_denom  = out_valid ? a[r][r]   : '0;
   assign done       = done_q;
   assign singular   = sing_q;
   assign piv_nz     = (a[p][k] != '0);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (load_fire && rc_last) state_n = SEARCH;
         SEARCH:  if (piv_nz)         state_n = (p == k) ? ELIM : SWAP;
                  else if (p == LAST) state_n = IDLE;
         SWAP:    state_n = ELIM;
         ELIM:    if (i == LAST)      state_n = (k == LAST) ? OUTPUT : SEARCH;
         OUTPUT:  if (out_fire && rc_last) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Elimination row: A[k][k]*row_i - A[i][k]*row_k. Evaluated at W bits,
   // which yields exactly the low W bits of the signed 2W products and
   // their difference.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         row_a[j] = a[k][k] * a[i][j]   - a[i][k] * a[k][j];
         row_g[j] = a[k][k] * aug[i][j] - a[i][k] * aug[k][j];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         armed  <= 1'b0;
         done_q <= 1'b0;
         sing_q <= 1'b0;
         k <= '0; p <= '0; i <= '0; r <= '0; c <= '0;
      end else begin
         state  <= state_n;
         armed  <= 1'b1;
         done_q <= 1'b0;
         sing_q <= 1'b0;
         case (state)
            IDLE: if (load_fire) begin
               if (c == LAST) begin
                  c <= '0;
                  r <= (r == LAST) ? '0 : r + 1'b1;
               end else c <= c + 1'b1;
               if (rc_last) begin k <= '0; p <= '0; end
            end
            SEARCH: begin
               i <= '0;
               if (!piv_nz) begin
                  if (p == LAST) begin
                     done_q <= 1'b1;
                     sing_q <= 1'b1;
                     k <= '0;
                     p <= '0;
                  end else p <= p + 1'b1;
               end
            end
            ELIM: begin
               if (i == LAST) begin
                  i <= '0;
                  if (k != LAST) begin
                     k <= k + 1'b1;
                     p <= k + 1'b1;
                  end
               end else i <= i + 1'b1;
            end
            OUTPUT: if (out_fire) begin
               if (c == LAST) begin
                  c <= '0;
                  if (r == LAST) begin
                     r      <= '0;
                     done_q <= 1'b1;
                  end else r <= r + 1'b1;
               end else c <= c + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Matrix storage carries no reset; its contents only matter once a
   // full load has completed.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (load_fire) begin
            a[r][c] <= load_data;
            if (rc_last)
               for (int x = 0; x < N; x++)
                  for (int y = 0; y < N; y++)
                     aug[x][y] <= (x == y) ? W'(1) : '0;
         end
         SWAP: for (int j = 0; j < N; j++) begin
            a[p][j]   <= a[k][j];
            a[k][j]   <= a[p][j];
            aug[p][j] <= aug[k][j];
            aug[k][j] <= aug[p][j];
         end
         ELIM: if (i != k) for (int j = 0; j < N; j++) begin
            a[i][j]   <= row_a[j];
            aug[i][j] <= row_g[j];
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_matrix_inverse_seq.sv
// Bench for matrix_inverse_seq: an N=2 and an N=5 instance share clock and
// reset; jobs run one at a time. Stimulus pushes expected beats, done
// events and compute latency into queues; a negedge monitor checks them.
module tb_matrix_inverse_seq;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         lv [2], lr [2], ov [2], ordy [2], ol [2], dn [2], sg [2];
   logic [W-1:0] ld [2], od [2], oden [2];

   matrix_inverse_seq #(.N(2), .W(W)) u_n2 (
      .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]),
      .load_data(ld[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_data(od[0]), .out_denom(oden[0]), .out_last(ol[0]),
      .done(dn[0]), .singular(sg[0]));

   matrix_inverse_seq #(.N(5), .W(W)) u_n5 (
      .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]),
      .load_data(ld[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_data(od[1]), .out_denom(oden[1]), .out_last(ol[1]),
      .done(dn[1]), .singular(sg[1]));

   typedef struct {int dut; logic [W-1:0] data; logic [W-1:0] den; logic last;} beat_t;
   typedef struct {int dut; logic sing;} done_t;

   beat_t        bq [$];
   done_t        dq [$];
   int           lat_q [$];
   logic [W-1:0] mat [64];
   int           nvec = 0, nerr = 0, cyc = 0;
   int           rmode [2];
   int           acc [2], t0 [2];
   bit           wl [2], pd [2];

   function automatic int nof(input int d);
      return (d == 0) ? 2 : 5;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, $signed(act), act, $signed(exp), exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      nvec++;
      nerr++;
      $display("FAIL %s at cycle %0d", nm, cyc);
   endtask

   // Reference: textbook fraction-free Gauss-Jordan on whole rows, modulo
   // 2^W, with latency counted from the search/swap/eliminate rules.
   task automatic model(input int d);
      int n, p, lat;
      bit sing;
      logic [W-1:0] a [8][8];
      logic [W-1:0] g [8][8];
      logic [W-1:0] t, akk, f;
      n = nof(d); lat = 0; sing = 0;
      for (int x = 0; x < n; x++)
         for (int y = 0; y < n; y++) begin
            a[x][y] = mat[x*n+y];
            g[x][y] = (x == y) ? 1 : 0;
         end
      for (int k = 0; k < n && !sing; k++) begin
         p = k;
         while (p < n && a[p][k] == 0) p++;
         if (p == n) sing = 1;
         else begin
            lat += (p - k + 1) + n;
            if (p != k) begin
               lat++;
               for (int j = 0; j < n; j++) begin
                  t = a[p][j]; a[p][j] = a[k][j]; a[k][j] = t;
                  t = g[p][j]; g[p][j] = g[k][j]; g[k][j] = t;
               end
            end
            akk = a[k][k];
            for (int x = 0; x < n; x++) if (x != k) begin
               f = a[x][k];
               for (int j = 0; j < n; j++) begin
                  a[x][j] = akk * a[x][j] - f * a[k][j];
                  g[x][j] = akk * g[x][j] - f * g[k][j];
               end
            end
         end
      end
      if (!sing) begin
         for (int x = 0; x < n; x++)
            for (int y = 0; y < n; y++)
               bq.push_back('{dut: d, data: g[x][y], den: a[x][x],
                              last: (x == n-1 && y == n-1)});
         lat_q.push_back(lat);
      end
      dq.push_back('{dut: d, sing: sing});
   endtask

   task automatic load(input int d);
      int n, t;
      n = nof(d);
      model(d);
      for (int e = 0; e < n*n; e++) begin
         if ($urandom_range(0, 3) == 0) begin
            lv[d] = 1'b0;
            @(posedge clk); #1;
         end
         lv[d] = 1'b1;
         ld[d] = mat[e];
         t = 0;
         @(negedge clk);
         while (!lr[d] && t < 100) begin @(negedge clk); t++; end
         if (t >= 100) fail("load_ready_timeout");
         @(posedge clk); #1;
      end
      lv[d] = 1'b0;
   endtask

   task automatic wait_job();
      int t;
      t = 0;
      while ((dq.size() != 0 || bq.size() != 0) && t < 3000) begin
         @(negedge clk); t++;
      end
      if (t >= 3000) begin
         fail("job_timeout");
         bq.delete(); dq.delete(); lat_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic set4(input int v0, input int v1, input int v2, input int v3);
      mat[0] = v0; mat[1] = v1; mat[2] = v2; mat[3] = v3;
   endtask

   task automatic set_ident5();
      for (int e = 0; e < 25; e++) mat[e] = (e % 6 == 0) ? 1 : 0;
   endtask

   initial begin
      ordy[0] = 1'b1; ordy[1] = 1'b1;
      forever begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++)
            case (rmode[d])
               0:       ordy[d] = 1'b1;
               1:       ordy[d] = ~ordy[d];
               default: ordy[d] = 1'($urandom_range(0, 1));
            endcase
      end
   end

   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            chk("rst_load_ready", W'(lr[d]), 0);
            chk("rst_out_valid", W'(ov[d]), 0);
            chk("rst_out_last", W'(ol[d]), 0);
            chk("rst_done", W'(dn[d]), 0);
            chk("rst_singular", W'(sg[d]), 0);
            chk("rst_out_data", od[d], 0);
            chk("rst_out_denom", oden[d], 0);
            acc[d] = 0; wl[d] = 0; pd[d] = 0;
         end else begin
            if (pd[d]) chk("load_ready_after_done", W'(lr[d]), 1);
            pd[d] = dn[d];
            if (lv[d] && lr[d]) begin
               acc[d]++;
               if (acc[d] == nof(d) * nof(d)) begin
                  acc[d] = 0; t0[d] = cyc; wl[d] = 1;
               end
            end
            if (ov[d]) begin
               if (wl[d]) begin
                  wl[d] = 0;
                  if (lat_q.size() == 0) fail("latency_unexpected");
                  else chk("compute_latency", W'(cyc - t0[d]), W'(lat_q.pop_front() + 1));
               end
               if (bq.size() == 0 || bq[0].dut != d) fail("unexpected_out_beat");
               else begin
                  chk("out_data", od[d], bq[0].data);
                  chk("out_denom", oden[d], bq[0].den);
                  chk("out_last", W'(ol[d]), W'(bq[0].last));
                  if (ordy[d]) void'(bq.pop_front());
               end
            end
            if (dn[d]) begin
               if (dq.size() == 0 || dq[0].dut != d) fail("unexpected_done");
               else begin
                  chk("beats_left_at_done", W'(bq.size()), 0);
                  chk("singular", W'(sg[d]), W'(dq[0].sing));
                  void'(dq.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int v;
      reset = 1'b1;
      rmode[0] = 0; rmode[1] = 0;
      lv[0] = 1'b0; lv[1] = 1'b0; ld[0] = '0; ld[1] = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("load_ready_before_edge", W'(lr[0]), 0);
      chk("load_ready_before_edge5", W'(lr[1]), 0);
      @(negedge clk);
      chk("load_ready_after_edge", W'(lr[0]), 1);
      chk("load_ready_after_edge5", W'(lr[1]), 1);
      @(posedge clk); #1;

      // 2x2 reference cases: plain, pivot swap, singular
      set4(2, 1, 1, 1);  load(0); wait_job();
      set4(0, 1, 1, 0);  load(0); wait_job();
      set4(1, 2, 2, 4);  load(0); wait_job();

      // 5x5 identity with alternating out_ready and junk on load_valid
      // while the block is busy
      rmode[1] = 1;
      set_ident5(); load(1);
      lv[1] = 1'b1; ld[1] = 32'hdead_beef;
      repeat (10) @(posedge clk);
      #1 lv[1] = 1'b0;
      wait_job();

      // abort a 5x5 job mid-elimination, then a fresh 2x2 job
      set_ident5(); load(1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      bq.delete(); dq.delete(); lat_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      set4(2, 1, 1, 1); load(0); wait_job();

      // randomized jobs: small values (hit zero pivots and singular cases)
      // and full-range values (exercise modular wrap)
      rmode[0] = 2; rmode[1] = 2;
      for (int j = 0; j < 24; j++) begin
         int d;
         d = j % 2;
         for (int e = 0; e < nof(d) * nof(d); e++) begin
            if (j % 6 == 5) mat[e] = $urandom;
            else begin
               v = int'($urandom_range(0, 4)) - 2;
               mat[e] = v;
            end
         end
         load(d);
         wait_job();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
